// File: rtl/lenet_pkg.sv
// rtl/lenet_pkg.sv - shared constants, FSM state type and int8 saturation helper for LeNet stages
package lenet_pkg;

    localparam int SHIFT = 16;

    localparam logic signed [63:0] Q_MAX  = 64'sd127;
    localparam logic signed [63:0] Q_MIN  = -64'sd128;
    localparam logic signed [63:0] Q_ZERO = 64'sd0;

    localparam logic [15:0] BASE_CONV1 = 16'd256;
    localparam logic [15:0] BASE_CONV2 = 16'd592;
    localparam logic [15:0] BASE_CONV3 = 16'd692;
    localparam logic [15:0] BASE_FC1   = 16'd722;
    localparam logic [15:0] BASE_FC2   = 16'd743;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // ReLU only raises the lower bound; the upper bound stays at +127.
    function automatic logic [7:0] sat_int8(input logic signed [63:0] q, input logic relu);
        logic signed [63:0] lo;
        lo = relu ? Q_ZERO : Q_MIN;
        if (q > Q_MAX)
            return 8'h7F;
        else if (q < lo)
            return lo[7:0];
        else
            return q[7:0];
    endfunction

endpackage

// File: rtl/requant_sat.sv
// rtl/requant_sat.sv - multiply by unsigned scale, floor-shift, saturate to int8, one register stage
module requant_sat
    import lenet_pkg::*;
#(
    parameter int SHIFT_AMT = lenet_pkg::SHIFT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic [31:0] in_data,
    input  logic [31:0] scale,
    input  logic        relu_en,
    output logic        out_valid,
    output logic        out_last,
    output logic [7:0]  out_byte
);

    logic signed [63:0] prod;
    logic signed [63:0] q;

    // The 32x33 signed product always fits in 64 bits, so truncation is exact.
    assign prod = $signed({{32{in_data[31]}}, in_data}) * $signed({32'd0, scale});
    assign q    = prod >>> SHIFT_AMT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_byte  <= 8'd0;
        end else begin
            out_valid <= in_valid;
            out_last  <= in_valid & in_last;
            if (in_valid)
                out_byte <= sat_int8(q, relu_en);
        end
    end

endmodule

// File: rtl/act_requant_writer.sv
// rtl/act_requant_writer.sv - requantize accumulator stream to int8 and pack four bytes per SRAM word
module act_requant_writer
    import lenet_pkg::*;
#(
    parameter int SHIFT  = lenet_pkg::SHIFT,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [31:0]       scale,
    input  logic              relu_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic [3:0]        sram_act_wea1,
    output logic [ADDR_W-1:0] sram_act_addr1,
    output logic [31:0]       sram_act_wdata1,
    output logic              busy,
    output logic              done
);

    state_e            state;
    logic [ADDR_W-1:0] addr_next;
    logic [31:0]       scale_q;
    logic              relu_q;
    logic              accept;
    logic              v1, last1;
    logic [31:0]       d1;
    logic              v2, last2;
    logic [7:0]        b2;
    logic [1:0]        lane;
    logic [31:0]       hold;
    logic [31:0]       merged;
    logic [3:0]        mask;

    assign accept   = in_valid & in_ready;
    assign in_ready = (state == ST_RUN);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            last1 <= 1'b0;
            d1    <= 32'd0;
        end else begin
            v1    <= accept;
            last1 <= accept & in_last;
            if (accept)
                d1 <= in_data;
        end
    end

    requant_sat #(.SHIFT_AMT(SHIFT)) u_requant_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v1),
        .in_last   (last1),
        .in_data   (d1),
        .scale     (scale_q),
        .relu_en   (relu_q),
        .out_valid (v2),
        .out_last  (last2),
        .out_byte  (b2)
    );

    // Unfilled lanes of hold are always zero, so OR-ing in the new byte is enough.
    always_comb begin
        merged = hold | ({24'd0, b2} << {lane, 3'b000});
        case (lane)
            2'd0:    mask = 4'b0001;
            2'd1:    mask = 4'b0011;
            2'd2:    mask = 4'b0111;
            default: mask = 4'b1111;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_act_wea1   <= 4'd0;
            sram_act_addr1  <= '0;
            sram_act_wdata1 <= 32'd0;
            addr_next       <= '0;
            scale_q         <= 32'd0;
            relu_q          <= 1'b0;
            lane            <= 2'd0;
            hold            <= 32'd0;
        end else begin
            sram_act_wea1 <= 4'd0;
            if (state == ST_IDLE && start) begin
                addr_next <= base_addr;
                scale_q   <= scale;
                relu_q    <= relu_en;
                lane      <= 2'd0;
                hold      <= 32'd0;
            end else if (v2) begin
                if (lane == 2'd3 || last2) begin
                    sram_act_wea1   <= mask;
                    sram_act_addr1  <= addr_next;
                    sram_act_wdata1 <= merged;
                    addr_next       <= addr_next + 1'b1;
                    lane            <= 2'd0;
                    hold            <= 32'd0;
                end else begin
                    hold <= merged;
                    lane <= lane + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start) state <= ST_RUN;
                ST_RUN:   if (accept && in_last) state <= ST_FLUSH;
                // Last element always produces a write; once it is on the port the pipe is drained.
                ST_FLUSH: if (!v1 && !v2 && sram_act_wea1 != 4'd0) state <= ST_DONE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_act_requant_writer.sv
// tb/tb_act_requant_writer.sv - self-checking bench for act_requant_writer
module tb_act_requant_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] base_addr;
    logic [31:0] scale;
    logic        relu_en;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [3:0]  sram_act_wea1;
    logic [15:0] sram_act_addr1;
    logic [31:0] sram_act_wdata1;
    logic        busy;
    logic        done;

    act_requant_writer #(.SHIFT(16), .ADDR_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .base_addr       (base_addr),
        .scale           (scale),
        .relu_en         (relu_en),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_last         (in_last),
        .sram_act_wea1   (sram_act_wea1),
        .sram_act_addr1  (sram_act_addr1),
        .sram_act_wdata1 (sram_act_wdata1),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  wea;
        logic [31:0] wdata;
        int          stamp;
    } wr_t;

    wr_t         obs_q[$];
    wr_t         exp_q[$];
    int          done_q[$];
    logic [31:0] data_q[$];

    int errors = 0;
    int checks = 0;

    int          m_lane;
    logic [31:0] m_word;
    logic [3:0]  m_mask;
    logic [15:0] m_addr;
    logic [31:0] m_scale;
    bit          m_relu;

    always @(negedge clk) begin
        if (sram_act_wea1 != 4'd0)
            obs_q.push_back('{sram_act_addr1, sram_act_wea1, sram_act_wdata1, cyc});
        if (done)
            done_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [31:0] d, input logic [31:0] sc, input bit relu);
        longint p, q, lo;
        p  = longint'($signed(d)) * longint'({32'd0, sc});
        q  = p >>> 16;
        lo = relu ? 0 : -128;
        if (q > 127) q = 127;
        if (q < lo)  q = lo;
        return q[7:0];
    endfunction

    task automatic model_beat(input logic [31:0] d, input bit last, input int stamp);
        logic [7:0] b;
        b = ref_byte(d, m_scale, m_relu);
        m_word = m_word | ({24'd0, b} << (8 * m_lane));
        m_mask = m_mask | 4'(1 << m_lane);
        if (m_lane == 3 || last) begin
            exp_q.push_back('{m_addr, m_mask, m_word, stamp + 3});
            m_addr = m_addr + 16'd1;
            m_lane = 0;
            m_word = 32'd0;
            m_mask = 4'd0;
        end else begin
            m_lane++;
        end
    endtask

    function automatic logic [31:0] rand_acc();
        if ($urandom_range(0, 3) == 0)
            return $urandom;
        return 32'($urandom_range(0, 600000)) - 32'd300000;
    endfunction

    // Called at a negedge; the beat is accepted at the following posedge.
    task automatic drive_beat(input logic [31:0] d, input bit last, input int gap);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        check("in_ready", in_ready, 1);
        model_beat(d, last, cyc);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = 1'($urandom_range(0, 1));
        repeat (gap) @(negedge clk);
    endtask

    task automatic run_layer(input logic [15:0] base, input logic [31:0] sc, input bit relu,
                             input int gapmode, input bit mid_start, input string tag);
        int n;
        obs_q.delete();
        exp_q.delete();
        done_q.delete();
        m_lane = 0; m_word = 32'd0; m_mask = 4'd0;
        m_addr = base; m_scale = sc; m_relu = relu;
        start = 1'b1; base_addr = base; scale = sc; relu_en = relu;
        @(negedge clk);
        start = 1'b0; base_addr = $urandom; scale = $urandom; relu_en = 1'($urandom_range(0, 1));
        check({tag, ".busy_after_start"}, busy, 1);
        foreach (data_q[i]) begin
            int g;
            g = (gapmode < 0) ? $urandom_range(0, 2) : gapmode;
            drive_beat(data_q[i], i == data_q.size() - 1, g);
            if (mid_start && i == 1) begin
                start = 1'b1; base_addr = 16'd0;
                @(negedge clk);
                start = 1'b0;
            end
        end
        repeat (8) @(negedge clk);
        check({tag, ".num_writes"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.w%0d.addr", tag, i),  obs_q[i].addr,  exp_q[i].addr);
            check($sformatf("%s.w%0d.wea", tag, i),   obs_q[i].wea,   exp_q[i].wea);
            check($sformatf("%s.w%0d.wdata", tag, i), obs_q[i].wdata, exp_q[i].wdata);
            check($sformatf("%s.w%0d.cycle", tag, i), obs_q[i].stamp, exp_q[i].stamp);
        end
        check({tag, ".done_pulses"}, done_q.size(), 1);
        if (done_q.size() > 0 && exp_q.size() > 0)
            check({tag, ".done_cycle"}, done_q[0], exp_q[exp_q.size()-1].stamp + 1);
        check({tag, ".busy_end"}, busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = 16'd0; scale = 32'd0; relu_en = 1'b0;
        in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.wea", sram_act_wea1, 0);
        check("reset.addr", sram_act_addr1, 0);
        check("reset.wdata", sram_act_wdata1, 0);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.in_ready", in_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);

        data_q = '{32'd20000, -32'sd5000, 32'd100000, 32'd1000};
        run_layer(16'd256, 32'd102, 1'b1, 0, 1'b0, "full");
        if (obs_q.size() > 0) check("full.const_wdata", obs_q[0].wdata, 32'h017F001F);

        data_q = '{-32'sd5000};
        run_layer(16'd100, 32'd102, 1'b0, 0, 1'b0, "norelu");
        if (obs_q.size() > 0) check("norelu.const_wdata", obs_q[0].wdata, 32'h000000F8);
        if (obs_q.size() > 0) check("norelu.const_wea", obs_q[0].wea, 4'b0001);

        data_q = '{-32'sd2000000};
        run_layer(16'd101, 32'd102, 1'b0, 0, 1'b0, "negsat");
        if (obs_q.size() > 0) check("negsat.const_wdata", obs_q[0].wdata, 32'h00000080);

        data_q = '{32'd20000, 32'd20000, 32'd20000, 32'd20000, 32'd20000, 32'd20000};
        run_layer(16'd592, 32'd102, 1'b1, 0, 1'b0, "partial");
        if (obs_q.size() > 1) check("partial.const_wdata1", obs_q[1].wdata, 32'h00001F1F);
        if (obs_q.size() > 1) check("partial.const_wea1", obs_q[1].wea, 4'b0011);

        data_q.delete();
        for (int i = 0; i < 8; i++) data_q.push_back(rand_acc());
        run_layer(16'd722, 32'd102, 1'b0, 1, 1'b0, "bubbles");

        data_q.delete();
        for (int i = 0; i < 7; i++) data_q.push_back(rand_acc());
        run_layer(16'd743, 32'd150, 1'b1, 0, 1'b1, "start_busy");

        for (int t = 0; t < 6; t++) begin
            logic [15:0] b;
            int len;
            len = $urandom_range(1, 13);
            b = (t == 0) ? 16'hFFFE : 16'($urandom);
            data_q.delete();
            for (int i = 0; i < len; i++) data_q.push_back(rand_acc());
            run_layer(b, (t == 1) ? $urandom : 32'($urandom_range(1, 400)),
                      1'($urandom_range(0, 1)), -1, 1'b0, $sformatf("rand%0d", t));
        end

        m_lane = 0; m_word = 32'd0; m_mask = 4'd0; m_addr = 16'd300;
        m_scale = 32'd102; m_relu = 1'b1;
        start = 1'b1; base_addr = 16'd300; scale = 32'd102; relu_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drive_beat(32'd20000, 1'b0, 0);
        drive_beat(32'd30000, 1'b0, 0);
        obs_q.delete();
        #2 rst_n = 1'b0;
        #1;
        check("midreset.wea", sram_act_wea1, 0);
        check("midreset.busy", busy, 0);
        check("midreset.done", done, 0);
        check("midreset.in_ready", in_ready, 0);
        repeat (4) @(negedge clk);
        check("midreset.no_write", obs_q.size(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        data_q.delete();
        for (int i = 0; i < 5; i++) data_q.push_back(rand_acc());
        run_layer(16'd700, 32'd102, 1'b1, 0, 1'b0, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/act_requant_writer.md
Name: act_requant_writer

Overview:
- Downstream writeback stage for every LeNet layer (CONV1-3, FC1, FC2).
- Consumes the stream of signed 32-bit accumulator results and requantizes each one as (acc*scale)>>>16.
- Applies optional ReLU and saturation to int8, then packs four bytes per 32-bit word.
- Writes the words to activation SRAM port 1 with byte enables, starting at a per-layer base address (CONV1 base 256, CONV2 592, CONV3 692, FC1 722, FC2 743).

Parameters:
- SHIFT, 16, arithmetic right-shift applied to acc*scale.
- ADDR_W, 16, SRAM address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches base_addr, scale, relu_en.
- base_addr  in  16  first word address for this layer.
- scale  in  32  unsigned layer scale (e.g. scale_CONV1=102).
- relu_en  in  1  1: clamp to [0,127]; 0: clamp to [-128,127].
- in_valid  in  1  accumulator word valid.
- in_ready  out  1  stage accepts a word this cycle.
- in_data  in  32  signed accumulator.
- in_last  in  1  marks the final element of the layer.
- sram_act_wea1  out  4  byte write enables.
- sram_act_addr1  out  16  word address.
- sram_act_wdata1  out  32  packed bytes.
- busy  out  1  high from the start edge until done.
- done  out  1  one-cycle pulse after the final write.

Behaviour:
- Reset (async, any time including mid-layer):
  - state IDLE; all pipeline valids, lane counter and address cleared.
  - All outputs 0; the pending partial word is discarded.
- FSM states and transitions:
  - IDLE -> RUN on start; busy=1 from the next cycle.
  - RUN -> FLUSH on an accepted beat with in_last=1.
  - FLUSH -> DONE once the pipeline is empty and the final write has been issued.
  - DONE -> IDLE after one cycle with done=1.
- start is ignored unless the state is IDLE.
- Handshake: in_ready = (state==RUN). A beat is accepted when in_valid & in_ready. Inputs are don't-care otherwise. No SRAM backpressure.
- Pipeline (all outputs registered):
  - E1: prod = signed(in_data) * signed({1'b0,scale}), 64-bit.
  - E2: q = prod>>>SHIFT, i.e. floor, no rounding. Then saturate: relu_en ? clamp(q,0,127) : clamp(q,-128,127). Take the low 8 bits.
  - E3: byte goes to lane k = element_index mod 4 (lane 0 = bits[7:0], first element).
- Write rule:
  - When lane 3 fills, or when the last element lands, assert wea for exactly one cycle.
  - wea carries one bit per filled lane: 4'hF for a full word, 4'b0001/0011/0111 for a partial last word.
  - The address increments by 1 after each write; it wraps modulo 2^ADDR_W and the wrap is not flagged.
  - Unfilled lanes in wdata are 0.
- Latency: the write for a word appears in the 3rd cycle after its completing beat's accept cycle.
- done asserts the cycle after the final write.
- Back-to-back beats give a full-throughput write every 4 accepts.
- Gaps in in_valid stall only the packer. The partial word is held and never written early.
- Layer of a single element: one write, wea=4'b0001.

Decomposition:
- Shared package lenet_pkg:
  - FSM state enum.
  - SHIFT.
  - int8 clamp bounds.
  - layer base address constants 256/592/692/722/743.
- Sub-module requant_sat (combinational plus one register stage: multiply, shift, saturate), reusable by a future pooling stage.

Test Plan:
- Full word: start base=256, scale=102, relu_en=1; stream 20000, -5000, 100000, 1000 (last) -> one write addr=256, wea=4'hF, wdata=0x017F001F; done one cycle later.
- No ReLU: relu_en=0, single element -5000 last, scale=102 -> addr=base, wea=4'b0001, wdata=0x000000F8; in_data=-2000000 -> byte 0x80.
- Partial word: 6 elements of 20000, base=592 -> writes addr 592 wea 4'hF wdata 0x1F1F1F1F, then addr 593 wea 4'b0011 wdata 0x00001F1F.
- Bubbles: in_valid toggles every other cycle over 8 elements -> exactly 2 writes, addresses consecutive, latency 3 cycles after each 4th accept.
- Reset mid-layer: assert rst_n=0 after 2 of 4 beats -> wea/busy/done/in_ready 0 immediately, no write. A new start after release begins at the new base_addr, lane 0.
- start while busy: pulse start with base=0 during RUN -> ignored; addresses continue from the original base.
